alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//   Parametrised, handshaked successor of the combinational 32-bit ALU. Registers
//   every result, keeps the existing opcode map and adds iterative MUL / DIVU / REMU
//   (one bit per cycle). Sits between the decode/operand-read stage and writeback;
//   the valid/ready handshake lets the pipeline stall on multi-cycle operations.
// PARAMETERS
//   WIDTH   32              operand/result width; even, >= 8
//   SHW     $clog2(WIDTH)   shift-amount bits taken from a[SHW-1:0]
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands + kontrol valid this cycle
//   in_ready   out  1      unit can accept an operation
//   a          in   WIDTH  operand A (shift amount for SLL/SRL/SRA)
//   b          in   WIDTH  operand B (shifted value / LUI source)
//   kontrol    in   4      opcode
//   out_valid  out  1      c / z_flag / err are valid
//   out_ready  in   1      consumer takes result this cycle
//   c          out  WIDTH  result
//   z_flag     out  1      1 when c == 0
//   err        out  1      1 for an unsupported opcode
// BEHAVIOUR
//   Opcodes: 0000 ADD a+b | 0100 SUB a-b | 0001 AND | 0101 OR | 0010 XOR
//     0110 LUI {b[WIDTH/2-1:0], WIDTH/2 zeros} | 0011 SLL b<<a[SHW-1:0]
//     0111 SRL b>>a[SHW-1:0] | 1111 SRA $signed(b)>>>a[SHW-1:0]
//     1000 MUL low WIDTH bits of a*b (unsigned) | 1001 DIVU a/b | 1010 REMU a%b
//     Other codes: c=0, z_flag=1, err=1, single-cycle latency.
//   ADD/SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
//   Operands and kontrol are captured on accept (in_valid & in_ready). They may
//     change after the accept cycle.
//   FSM states: IDLE, BUSY, DONE.
//     IDLE: in_ready=1. On accept of a single-cycle op -> DONE, with the result
//       registered at that edge. On accept of MUL/DIVU/REMU -> BUSY, count=0.
//     BUSY: in_ready=0. One iteration per cycle. Leave after WIDTH iterations
//       (count==WIDTH-1) -> DONE.
//       MUL: shift-add; accumulator 2*WIDTH bits.
//       DIV: restoring; WIDTH-bit remainder + 1 guard bit.
//     DONE: out_valid=1. c, z_flag and err stay stable until out_ready=1, then -> IDLE.
//       No new accept is allowed in DONE.
//   Latency (accept edge T): single-cycle op has out_valid=1 after T+1.
//     MUL/DIVU/REMU have out_valid=1 after T+WIDTH+1.
//     Throughput: at most one op per 2 cycles (IDLE->DONE->IDLE).
//   z_flag is computed from the final registered c, never from a partial value.
//   Divide by zero (b==0): DIVU gives c = all ones; REMU gives c = a. Normal
//     WIDTH-cycle latency, err=0.
//   Shift amount >= WIDTH cannot occur; only a[SHW-1:0] is used.
//   Reset (any state, including mid-BUSY): state=IDLE, in_ready=1 in the next cycle,
//     out_valid=0, c=0, z_flag=0, err=0, count=0. Any in-flight op is dropped.
//   in_valid is ignored while in_ready=0. Upstream must hold the op until it is accepted.
// TESTING
//   1 ADD a=32'hFFFF_FFFF b=1, out_ready=1 -> c=0, z_flag=1, out_valid exactly 1
//     cycle after accept.
//   2 SRA b=32'h8000_0000 a=4; LUI b=32'h0000_1234 -> c=32'hF800_0000, then
//     c=32'h1234_0000, z_flag=0 both.
//   3 MUL a=32'h0001_0001 b=32'h0001_0001 -> c=32'h0002_0001 exactly 33 cycles after
//     accept; in_ready=0 throughout BUSY.
//   4 DIVU/REMU a=100 b=7 -> 14 then 2; a=5 b=0 -> 32'hFFFF_FFFF then 5, err=0.
//   5 Backpressure: out_ready=0 for 5 cycles in DONE -> c stable, in_ready=0, new
//     in_valid ignored; out_ready=1 -> IDLE.
//   6 rst=1 at BUSY count=10 -> next cycle out_valid=0, c=0, in_ready=1; fresh ADD
//     2+3 -> c=5. Opcode 4'b1011 -> c=0, z_flag=1, err=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle between the operand-read stage,
// the multi-cycle ALU and writeback.
//   master : upstream/downstream side (drives operands and out_ready)
//   slave  : ALU side (drives in_ready and the registered result)
//   in_valid/in_ready     operand handshake
//   a, b, kontrol         operands and opcode
//   out_valid/out_ready   result handshake
//   c, z_flag, err        result, zero flag, unsupported-opcode flag
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       kontrol;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             z_flag;
  logic             err;

  modport master (
    output in_valid, a, b, kontrol, out_ready,
    input  in_ready, out_valid, c, z_flag, err
  );

  modport slave (
    input  in_valid, a, b, kontrol, out_ready,
    output in_ready, out_valid, c, z_flag, err
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered results. Single-cycle ops complete
// one cycle after accept; MUL/DIVU/REMU iterate one bit per cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_mc_if.slave (operand handshake in, result handshake out)
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned HALF = WIDTH / 2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [W2-1:0]    r_acc;   // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0] r_opd;   // MUL: multiplicand; DIV: divisor
  logic [SHW-1:0]   r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_z;
  logic             r_err;

  logic             w_accept;
  logic             w_is_mc;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_err;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_trial;
  logic [W2-1:0]    w_acc_nx;
  logic [WIDTH-1:0] w_mc_res;
  logic [SHW-1:0]   w_sh;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_is_mc  = (bus.kontrol == OP_MUL) || (bus.kontrol == OP_DIVU) ||
                    (bus.kontrol == OP_REMU);
  assign w_sh     = bus.a[SHW-1:0];

  // Single-cycle result straight from the live operands at accept
  always_comb begin
    w_sc_res = '0;
    w_sc_err = 1'b0;
    case (bus.kontrol)
      OP_ADD:  w_sc_res = bus.a + bus.b;
      OP_SUB:  w_sc_res = bus.a - bus.b;
      OP_AND:  w_sc_res = bus.a & bus.b;
      OP_OR:   w_sc_res = bus.a | bus.b;
      OP_XOR:  w_sc_res = bus.a ^ bus.b;
      OP_LUI:  w_sc_res = {bus.b[HALF-1:0], {HALF{1'b0}}};
      OP_SLL:  w_sc_res = bus.b << w_sh;
      OP_SRL:  w_sc_res = bus.b >> w_sh;
      OP_SRA:  w_sc_res = WIDTH'($signed(bus.b) >>> w_sh);
      default: w_sc_err = 1'b1;
    endcase
  end

  // One multiply (shift-add) or restoring-divide step
  always_comb begin
    w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_opd & {WIDTH{r_acc[0]}}};
    w_trial   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opd};
    if (r_op == OP_MUL) begin
      w_acc_nx = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      w_acc_nx = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      // restore: remainder just takes the next dividend bit, quotient bit 0
      w_acc_nx = {r_acc[W2-2:0], 1'b0};
    end
    w_mc_res = (r_op == OP_REMU) ? w_acc_nx[W2-1:WIDTH] : w_acc_nx[WIDTH-1:0];
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_acc       <= '0;
      r_opd       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_z         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= bus.kontrol;
            r_in_ready <= 1'b0;
            if (w_is_mc) begin
              r_state <= BUSY;
              r_cnt   <= '0;
              if (bus.kontrol == OP_MUL) begin
                r_opd <= bus.a;
                r_acc <= {{WIDTH{1'b0}}, bus.b};
              end else begin
                r_opd <= bus.b;
                r_acc <= {{WIDTH{1'b0}}, bus.a};
              end
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_c         <= w_sc_res;
              r_z         <= (w_sc_res == '0);
              r_err       <= w_sc_err;
            end
          end
        end
        BUSY: begin
          r_acc <= w_acc_nx;
          r_cnt <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_c         <= w_mc_res;
            r_z         <= (w_mc_res == '0);
            r_err       <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;
  assign bus.z_flag    = r_z;
  assign bus.err       = r_err;

endmodule
